// File: rtl/count_uart_tx.sv
// Snapshots a counter value on request and sends it out MSB byte first as
// back-to-back 8N1 UART frames on a single registered pin.
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int NUM_BYTES    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_BYTES-1:0] count_in,
  input  logic                   send,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (NUM_BYTES > 2) ? $clog2(NUM_BYTES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [BW-1:0] byte_idx;
  logic [W-1:0]  shadow;
  logic [7:0]    cur_byte;
  logic          bit_end;

  // The shadow shifts left after each byte, so the byte on the wire is always its top byte.
  assign cur_byte = shadow[W-1 -: 8];
  assign bit_end  = (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shadow   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        timer <= bit_end ? '0 : timer + 1'b1;
      end
      case (state)
        IDLE: begin
          if (send) begin
            shadow   <= count_in;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= cur_byte[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              tx      <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (byte_idx < BYTE_LAST) begin
              byte_idx <= byte_idx + 1'b1;
              shadow   <= shadow << 8;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Parameter sanity; only meaningful in simulation.
  param_legal: assert property (@(posedge clk) (CLKS_PER_BIT >= 2) && (NUM_BYTES >= 1));

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: a UART decoder on tx pops expected bytes from a
// scoreboard queue; scenario tasks check timing, busy/done and reset behaviour.
module tb_count_uart_tx;

  localparam int CPB = 4;
  localparam int NB  = 2;
  localparam int W   = 8 * NB;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic [W-1:0] count_in = '0;
  logic         send     = 1'b0;
  logic         tx;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  count_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_in (count_in),
    .send     (send),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  // Frame decoder: samples each bit in its middle, checks start/stop and data.
  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [9:0] mon_bits   = '0;
  logic [7:0] mon_exp    = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
    end
    if (rst_n && mon_active && (mon_cnt % CPB == CPB / 2)) begin
      mon_bits[mon_cnt / CPB] = tx;
      if (mon_cnt / CPB == 9) begin
        mon_active = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL frame_unexpected: got frame %b, no byte expected", mon_bits);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_bits !== {1'b1, mon_exp, 1'b0}) begin
            n_err++;
            $display("FAIL frame_data: got stop/data/start %b, expected %b (byte %02h)",
                     mon_bits, {1'b1, mon_exp, 1'b0}, mon_exp);
          end
        end
      end
    end
  end

  task automatic test_reset();
    send = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_hold: tx/busy/done=%b expected 100", {tx, busy, done});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({tx, busy, done} !== 3'b100) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: tx/busy/done=%b expected 100", i, {tx, busy, done});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] byt;
    logic       exp_bit;
    logic       bad;
    logic       act;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    @(negedge clk);
    count_in = 16'hA55A;
    send     = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    @(negedge clk);
    send = 1'b0;
    for (int b = 0; b < 20; b++) begin
      byt = (b < 10) ? 8'hA5 : 8'h5A;
      if (b % 10 == 0)      exp_bit = 1'b0;
      else if (b % 10 == 9) exp_bit = 1'b1;
      else                  exp_bit = byt[(b % 10) - 1];
      bad = 1'b0;
      act = exp_bit;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== exp_bit) begin
          bad = 1'b1;
          act = tx;
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        @(negedge clk);
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL single_tx_bit %0d: got %b expected %b", b, act, exp_bit);
      end
    end
    n_cmp++;
    if (busy_cnt != 80 || done_cnt != 0) begin
      n_err++;
      $display("FAIL single_busy_len: busy %0d cycles, early done %0d; expected 80, 0", busy_cnt, done_cnt);
    end
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL single_end: busy/done=%b expected 01", {busy, done});
    end
    @(negedge clk);
    n_cmp++;
    if ({tx, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL single_after: tx/busy/done=%b expected 100", {tx, busy, done});
    end
  endtask

  task automatic test_stability();
    int  done_cnt = 0;
    logic ended = 1'b0;
    @(negedge clk);
    count_in = 16'h1234;
    send     = 1'b1;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    for (int k = 0; k < 200 && !ended; k++) begin
      @(negedge clk);
      send     = 1'b0;
      count_in = count_in + 16'd1;
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b0) ended = 1'b1;
    end
    n_cmp++;
    if (!ended || done_cnt != 1) begin
      n_err++;
      $display("FAIL stability_end: ended=%b done pulses %0d expected 1, 1", ended, done_cnt);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stability_bytes: %0d bytes outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    int busy_cnt = 0;
    int done_cnt = 0;
    @(negedge clk);
    count_in = 16'hC3E1;
    send     = 1'b1;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hE1);
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      send = (cyc == 29);
      if (cyc == 29) count_in = 16'h0F0F;
    end
    n_cmp++;
    if (busy_cnt != 80 || done_cnt != 1) begin
      n_err++;
      $display("FAIL busy_ignore: busy %0d cycles, done pulses %0d; expected 80, 1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_continuous();
    int   busy_cnt = 0;
    logic seen = 1'b0;
    @(negedge clk);
    count_in = 16'h00FF;
    send     = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    n_cmp++;
    if (!seen || busy_cnt != 80) begin
      n_err++;
      $display("FAIL cont_first: done seen=%b busy %0d cycles expected 1, 80", seen, busy_cnt);
    end
    n_cmp++;
    if ({tx, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL cont_gap: tx/busy=%b expected 10", {tx, busy});
    end
    count_in = 16'hFF00;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    @(negedge clk);
    n_cmp++;
    if ({tx, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL cont_restart: tx/busy=%b expected 01", {tx, busy});
    end
    send     = 1'b0;
    busy_cnt = 1;
    seen     = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    n_cmp++;
    if (!seen || busy_cnt != 80) begin
      n_err++;
      $display("FAIL cont_second: done seen=%b busy %0d cycles expected 1, 80", seen, busy_cnt);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    count_in = 16'h353C;
    send     = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (17) @(negedge clk);
    n_cmp++;
    if ({tx, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL midreset_pre: tx/busy=%b expected 01", {tx, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL midreset_async: tx/busy/done=%b expected 100", {tx, busy, done});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({tx, busy, done} !== 3'b100) begin
        n_err++;
        $display("FAIL midreset_idle cycle %0d: tx/busy/done=%b expected 100", i, {tx, busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stability();
    test_busy_ignore();
    test_continuous();
    test_mid_reset();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_bytes: %0d expected bytes never seen", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
Downstream consumer of the free-running counter value in the tt_um_mrmola top. On request, it snapshots the count and serialises it MSB-byte-first as standard 8N1 UART frames on a single output pin. This lets the count be read off-chip over one IO without changing the counter itself.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit; legal range is 2 or more.
NUM_BYTES, 2, bytes per snapshot; the count width is 8*NUM_BYTES.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
count_in  input  8*NUM_BYTES  live counter value.
send  input  1  level-sampled request to transmit one snapshot.
tx  output  1  UART line; idles high.
busy  output  1  high while a snapshot is being transmitted.
done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values (rst_n low, asynchronous): tx=1, busy=0, done=0, state=IDLE, all counters=0, shadow register=0.
- Reset mid-transmission aborts the snapshot immediately. tx returns to 1 with no further frames.
- All outputs are registered; there is no combinational path from input to output.
- States and transitions:
  - IDLE: if send=1 at a rising edge, capture count_in into the shadow register, go to START, set busy=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte index < NUM_BYTES-1, increment it and go to START;
    - otherwise go to IDLE, set busy=0, pulse done=1.
- Byte order: byte 0 is shadow[8*NUM_BYTES-1 -: 8] (most significant), the last byte is shadow[7:0]. Frames are back to back with no idle gap between them.
- Timing:
  - tx falls on the first edge after send is sampled (1-cycle latency).
  - Total busy time is NUM_BYTES*10*CLKS_PER_BIT cycles.
  - done and busy=0 appear on the same edge.
- send while busy=1 is ignored; it is neither queued nor used to re-snapshot.
- send held high continuously restarts on the edge after done. That edge samples send in IDLE, so there is exactly one idle cycle (tx=1) between snapshots.
- count_in changing during transmission has no effect; only the shadow register is sent.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. It is sized as $clog2(CLKS_PER_BIT), with a minimum of 1 bit.
- Bit index is 3 bits; byte index is $clog2(NUM_BYTES), with a minimum of 1 bit.
- Combinations NUM_BYTES<1 or CLKS_PER_BIT<2 are out of scope (simulation assertion only).

Test Plan:
1. Reset idle: rst_n=0 then released, send=0 for 50 cycles -> tx=1, busy=0, done=0 throughout.
2. Single snapshot: CLKS_PER_BIT=4, count_in=16'hA55A, 1-cycle send pulse.
   - tx bit sequence, each bit 4 cycles: 0,1,0,1,0,0,1,0,1,1, then 0,0,1,0,1,1,0,1,0,1.
   - busy is high for exactly 80 cycles; done pulses once at the end.
3. Snapshot stability: count_in=16'h1234 at the send edge, then count_in increments every cycle -> decoded bytes are 0x12, 0x34.
4. Request while busy: send pulsed again at cycle 30 of a transfer -> no effect; one done pulse, 80 busy cycles total.
5. Continuous send: send held high, count_in=16'h00FF then 16'hFF00 -> two snapshots separated by exactly one tx=1 idle cycle; bytes are 00, FF, FF, 00.
6. Mid-frame reset: rst_n asserted low during the DATA bit 3 of byte 0 -> tx=1 and busy=0 asynchronously. After release with send=0, the line stays idle with no residual frame.
